// File: rtl/semaforo_pkg.sv
// semaforo_pkg: shared definitions for the semaforo monitor.
//   - lamp codes {verde, amarelo, vermelho}
//   - default phase durations for semaphore A, in clock cycles
//   - lamp tracker synchronisation states
//   - helpers: code validity, legal successor colour, 8-bit saturating increment
package semaforo_pkg;

  localparam logic [2:0] LUZ_VERDE    = 3'b100;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b001;

  localparam logic [7:0] DUR_VERDE    = 8'd1;
  localparam logic [7:0] DUR_AMARELO  = 8'd3;
  localparam logic [7:0] DUR_VERMELHO = 8'd2;

  typedef enum logic [1:0] {
    TRK_UNSYNC = 2'd0,
    TRK_FIRST  = 2'd1,
    TRK_RUN    = 2'd2
  } trk_state_t;

  function automatic logic luz_valida(input logic [2:0] c);
    return (c == LUZ_VERDE) || (c == LUZ_AMARELO) || (c == LUZ_VERMELHO);
  endfunction

  // Only successor allowed after colour c; 000 for an invalid code.
  function automatic logic [2:0] luz_seguinte(input logic [2:0] c);
    case (c)
      LUZ_VERDE:    return LUZ_AMARELO;
      LUZ_AMARELO:  return LUZ_VERMELHO;
      LUZ_VERMELHO: return LUZ_VERDE;
      default:      return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/semaforo_monitor_if.sv
// semaforo_monitor_if: observed traffic-light buses plus monitor results.
//   bt, A, B       : button and lamp buses (driven by the system / bench)
//   err_*          : sticky error flags
//   bt_pending     : pedestrian request waiting for service
//   bt_latency     : latency of last served request, cycles
//   ciclos         : number of A red->green transitions
// master = side driving the buses, slave = the monitor.
interface semaforo_monitor_if;
  logic        bt;
  logic [2:0]  A;
  logic [2:0]  B;
  logic        err_onehot;
  logic        err_conflict;
  logic        err_seq;
  logic        err_dur;
  logic        err_any;
  logic        bt_pending;
  logic [7:0]  bt_latency;
  logic [15:0] ciclos;

  modport master (
    output bt, A, B,
    input  err_onehot, err_conflict, err_seq, err_dur, err_any,
           bt_pending, bt_latency, ciclos
  );

  modport slave (
    input  bt, A, B,
    output err_onehot, err_conflict, err_seq, err_dur, err_any,
           bt_pending, bt_latency, ciclos
  );
endinterface

// File: rtl/lamp_tracker.sv
// lamp_tracker: follows one lamp bus and flags illegal codes and colour changes.
//   clk, rst  : clock, synchronous active-high reset
//   luz       : current lamp sample
//   changed   : valid sample differs from tracked colour (after sync)
//   prev      : tracked colour (registered)
//   run       : samples spent in tracked colour, saturating (0 when RUN_EN=0)
//   run_full  : current run started at a real change, so it is a whole phase
//   bad_code  : sample is not G/Y/R
//   bad_seq   : change is not G->Y, Y->R or R->G
//
// state      | meaning
// TRK_UNSYNC | nothing tracked yet; first valid sample loads prev
// TRK_FIRST  | synced, current run began at sync and is partial
// TRK_RUN    | synced, current run began at a colour change
module lamp_tracker
  import semaforo_pkg::*;
#(
  parameter bit RUN_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] luz,
  output logic       changed,
  output logic [2:0] prev,
  output logic [7:0] run,
  output logic       run_full,
  output logic       bad_code,
  output logic       bad_seq
);

  trk_state_t state, state_nxt;
  logic [2:0] prev_q;
  logic       valid;
  logic       load;

  assign valid    = luz_valida(luz);
  assign bad_code = ~valid;
  assign prev     = prev_q;
  assign run_full = (state == TRK_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= TRK_UNSYNC;
    else     state <= state_nxt;
  end

  // Invalid samples leave the tracker untouched.
  always_comb begin
    state_nxt = state;
    changed   = 1'b0;
    bad_seq   = 1'b0;
    load      = 1'b0;
    case (state)
      TRK_UNSYNC: begin
        if (valid) begin
          state_nxt = TRK_FIRST;
          load      = 1'b1;
        end
      end
      TRK_FIRST, TRK_RUN: begin
        if (valid && (luz != prev_q)) begin
          changed   = 1'b1;
          bad_seq   = (luz != luz_seguinte(prev_q));
          load      = 1'b1;
          state_nxt = TRK_RUN;
        end
      end
      default: state_nxt = TRK_UNSYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       prev_q <= 3'b000;
    else if (load) prev_q <= luz;
  end

  generate
    if (RUN_EN) begin : g_run
      logic [7:0] run_q;
      always_ff @(posedge clk) begin
        if (rst)                              run_q <= 8'd0;
        else if (load)                        run_q <= 8'd1;
        else if (valid && state != TRK_UNSYNC) run_q <= sat_inc8(run_q);
      end
      assign run = run_q;
    end else begin : g_norun
      assign run = 8'd0;
    end
  endgenerate

endmodule

// File: rtl/semaforo_monitor.sv
// semaforo_monitor: passive checker for the semaforo traffic-light controller.
//   clk, rst : clock, synchronous active-high reset
//   mon      : semaforo_monitor_if.slave (bt, A, B in; flags and counters out)
// Optional feature macro: SEMAFORO_MON_DURATION_CHECK_EN builds the A run
// counter and phase-duration comparison; without it err_dur is constant 0.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter logic [7:0] VERDE_CYC    = DUR_VERDE,
  parameter logic [7:0] AMARELO_CYC  = DUR_AMARELO,
  parameter logic [7:0] VERMELHO_CYC = DUR_VERMELHO
) (
  input  logic               clk,
  input  logic               rst,
  semaforo_monitor_if.slave  mon
);

`ifdef SEMAFORO_MON_DURATION_CHECK_EN
  localparam bit DUR_EN = 1'b1;
`else
  localparam bit DUR_EN = 1'b0;
`endif

  logic       changed_a, changed_b;
  logic [2:0] prev_a, prev_b;
  logic [7:0] run_a, run_b;
  logic       run_full_a, run_full_b;
  logic       bad_code_a, bad_code_b;
  logic       bad_seq_a, bad_seq_b;

  lamp_tracker #(.RUN_EN(DUR_EN)) u_trk_a (
    .clk(clk), .rst(rst), .luz(mon.A),
    .changed(changed_a), .prev(prev_a), .run(run_a), .run_full(run_full_a),
    .bad_code(bad_code_a), .bad_seq(bad_seq_a)
  );

  lamp_tracker #(.RUN_EN(1'b0)) u_trk_b (
    .clk(clk), .rst(rst), .luz(mon.B),
    .changed(changed_b), .prev(prev_b), .run(run_b), .run_full(run_full_b),
    .bad_code(bad_code_b), .bad_seq(bad_seq_b)
  );

  logic unused_b;
  assign unused_b = ^{changed_b, prev_b, run_b, run_full_b};

  logic dur_bad;
`ifdef SEMAFORO_MON_DURATION_CHECK_EN
  logic [7:0] dur_esperada;
  always_comb begin
    dur_esperada = VERDE_CYC;
    case (prev_a)
      LUZ_AMARELO:  dur_esperada = AMARELO_CYC;
      LUZ_VERMELHO: dur_esperada = VERMELHO_CYC;
      default:      dur_esperada = VERDE_CYC;
    endcase
  end
  // The run that ends at the first change after sync is partial: skip it.
  assign dur_bad = changed_a & run_full_a & (run_a != dur_esperada);
`else
  logic unused_dur;
  assign unused_dur = ^{run_a, run_full_a, VERDE_CYC, AMARELO_CYC, VERMELHO_CYC};
  assign dur_bad    = 1'b0;
`endif

  logic conflict, a_to_r, ciclo, bt_edge;
  assign conflict = ~bad_code_a & ~bad_code_b &
                    (mon.A != LUZ_VERMELHO) & (mon.B != LUZ_VERMELHO);
  assign a_to_r   = changed_a & (mon.A == LUZ_VERMELHO);
  assign ciclo    = changed_a & (prev_a == LUZ_VERMELHO) & (mon.A == LUZ_VERDE);

  logic        err_onehot_q, err_conflict_q, err_seq_q, err_dur_q, err_any_q;
  logic        bt_q, pending_q;
  logic [7:0]  lat_q, lat_nxt, bt_latency_q;
  logic [15:0] ciclos_q;

  assign bt_edge = mon.bt & ~bt_q;
  assign lat_nxt = sat_inc8(lat_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_onehot_q   <= 1'b0;
      err_conflict_q <= 1'b0;
      err_seq_q      <= 1'b0;
      err_dur_q      <= 1'b0;
      err_any_q      <= 1'b0;
      bt_q           <= 1'b0;
      pending_q      <= 1'b0;
      lat_q          <= 8'd0;
      bt_latency_q   <= 8'd0;
      ciclos_q       <= 16'd0;
    end else begin
      err_onehot_q   <= err_onehot_q   | bad_code_a | bad_code_b;
      err_conflict_q <= err_conflict_q | conflict;
      err_seq_q      <= err_seq_q      | bad_seq_a | bad_seq_b;
      err_dur_q      <= err_dur_q      | dur_bad;
      // Built from the flag registers, so it trails them by one edge.
      err_any_q      <= err_onehot_q | err_conflict_q | err_seq_q | err_dur_q;
      bt_q           <= mon.bt;
      if (ciclo) ciclos_q <= ciclos_q + 16'd1;
      // lat counts the detecting edge as 0; the service edge counts too.
      if (pending_q) begin
        lat_q <= lat_nxt;
        if (a_to_r) begin
          bt_latency_q <= lat_nxt;
          pending_q    <= 1'b0;
        end
      end else if (bt_edge) begin
        if (a_to_r) begin
          bt_latency_q <= 8'd0;
        end else begin
          pending_q <= 1'b1;
          lat_q     <= 8'd0;
        end
      end
    end
  end

  assign mon.err_onehot   = err_onehot_q;
  assign mon.err_conflict = err_conflict_q;
  assign mon.err_seq      = err_seq_q;
  assign mon.err_dur      = err_dur_q;
  assign mon.err_any      = err_any_q;
  assign mon.bt_pending   = pending_q;
  assign mon.bt_latency   = bt_latency_q;
  assign mon.ciclos       = ciclos_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// tb_semaforo_monitor: scoreboard bench for semaforo_monitor. A reference model
// computes the expected outputs after each edge and queues them; a monitor
// compares the DUT outputs one time unit after every rising edge.
module tb_semaforo_monitor;
  import semaforo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  semaforo_monitor_if mif();

  semaforo_monitor #(
    .VERDE_CYC(8'd1), .AMARELO_CYC(8'd3), .VERMELHO_CYC(8'd2)
  ) dut (
    .clk(clk), .rst(rst), .mon(mif)
  );

  typedef struct {
    bit oh, cf, sq, du, any, pend;
    int blat;
    int cic;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: colours as 0=G, 1=Y, 2=R, -1 invalid.
  int dur[3] = '{1, 3, 2};
  bit sa_sync, sa_first, sb_sync;
  int sa_prev, sa_run, sb_prev;
  bit f_oh, f_cf, f_sq, f_du, f_any;
  bit m_pend, m_btq;
  int m_lat, m_blat, m_cic;

  function automatic int cidx(input logic [2:0] c);
    case (c)
      3'b100:  return 0;
      3'b010:  return 1;
      3'b001:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] code(input int c);
    case (c)
      0:       return LUZ_VERDE;
      1:       return LUZ_AMARELO;
      default: return LUZ_VERMELHO;
    endcase
  endfunction

  task automatic model_reset();
    sa_sync = 0; sa_first = 0; sa_prev = 0; sa_run = 0;
    sb_sync = 0; sb_prev = 0;
    f_oh = 0; f_cf = 0; f_sq = 0; f_du = 0; f_any = 0;
    m_pend = 0; m_btq = 0; m_lat = 0; m_blat = 0; m_cic = 0;
  endtask

  task automatic model_step(input bit r, input bit b, input logic [2:0] a, input logic [2:0] bb);
    exp_t e;
    int ca, cb;
    bit any_n, a_to_r, edge_b;
    if (r) begin
      model_reset();
    end else begin
      ca = cidx(a);
      cb = cidx(bb);
      any_n = f_oh | f_cf | f_sq | f_du;
      a_to_r = 0;
      if (ca < 0 || cb < 0) f_oh = 1;
      if (ca >= 0 && cb >= 0 && ca != 2 && cb != 2) f_cf = 1;
      if (ca >= 0) begin
        if (!sa_sync) begin
          sa_sync = 1; sa_first = 1; sa_prev = ca; sa_run = 1;
        end else if (ca == sa_prev) begin
          sa_run = (sa_run < 255) ? sa_run + 1 : 255;
        end else begin
          if (ca != (sa_prev + 1) % 3) f_sq = 1;
`ifdef SEMAFORO_MON_DURATION_CHECK_EN
          if (!sa_first && sa_run != dur[sa_prev]) f_du = 1;
`endif
          if (sa_prev == 2 && ca == 0) m_cic = (m_cic + 1) % 65536;
          if (ca == 2) a_to_r = 1;
          sa_prev = ca; sa_run = 1; sa_first = 0;
        end
      end
      if (cb >= 0) begin
        if (!sb_sync) begin
          sb_sync = 1; sb_prev = cb;
        end else if (cb != sb_prev) begin
          if (cb != (sb_prev + 1) % 3) f_sq = 1;
          sb_prev = cb;
        end
      end
      edge_b = b && !m_btq;
      m_btq = b;
      if (m_pend) begin
        m_lat = (m_lat < 255) ? m_lat + 1 : 255;
        if (a_to_r) begin
          m_blat = m_lat; m_pend = 0;
        end
      end else if (edge_b) begin
        if (a_to_r) m_blat = 0;
        else begin
          m_pend = 1; m_lat = 0;
        end
      end
      f_any = any_n;
    end
    e.oh = f_oh; e.cf = f_cf; e.sq = f_sq; e.du = f_du; e.any = f_any;
    e.pend = m_pend; e.blat = m_blat; e.cic = m_cic;
    q.push_back(e);
  endtask

  task automatic step(input bit b, input logic [2:0] a, input logic [2:0] bb);
    @(negedge clk);
    rst = 1'b0; mif.bt = b; mif.A = a; mif.B = bb;
    model_step(1'b0, b, a, bb);
  endtask

  task automatic reset_dut(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; mif.bt = 1'b0;
      model_step(1'b1, 1'b0, mif.A, mif.B);
    end
  endtask

  task automatic phase(input logic [2:0] a, input logic [2:0] bb, input int n);
    for (int i = 0; i < n; i++) step(1'b0, a, bb);
  endtask

  // One A cycle; B shows G then Y while A is red, red otherwise.
  task automatic cycle_ab(input int g, input int y, input int r);
    phase(LUZ_VERDE, LUZ_VERMELHO, g);
    phase(LUZ_AMARELO, LUZ_VERMELHO, y);
    for (int i = 0; i < r; i++)
      step(1'b0, LUZ_VERMELHO,
           (r < 2) ? LUZ_VERMELHO : ((i == r - 1) ? LUZ_AMARELO : LUZ_VERDE));
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exv);
    if (act !== exv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exv);
    end
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_vec++;
      chk("err_onehot",   {15'd0, mif.err_onehot},   {15'd0, mon_e.oh});
      chk("err_conflict", {15'd0, mif.err_conflict}, {15'd0, mon_e.cf});
      chk("err_seq",      {15'd0, mif.err_seq},      {15'd0, mon_e.sq});
      chk("err_dur",      {15'd0, mif.err_dur},      {15'd0, mon_e.du});
      chk("err_any",      {15'd0, mif.err_any},      {15'd0, mon_e.any});
      chk("bt_pending",   {15'd0, mif.bt_pending},   {15'd0, mon_e.pend});
      chk("bt_latency",   {8'd0, mif.bt_latency},    mon_e.blat[15:0]);
      chk("ciclos",       mif.ciclos,                mon_e.cic[15:0]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int col, len;
  logic [2:0] ra, rb;

  initial begin
    mif.bt = 1'b0; mif.A = LUZ_VERMELHO; mif.B = LUZ_VERMELHO;
    model_reset();
    reset_dut(2);

    // Nominal cycles: no flags, ciclos counts R->G.
    repeat (4) cycle_ab(1, 3, 2);

    // Short yellow: duration error only.
    reset_dut(1);
    phase(LUZ_VERDE, LUZ_VERMELHO, 1);
    phase(LUZ_AMARELO, LUZ_VERMELHO, 2);
    phase(LUZ_VERMELHO, LUZ_VERMELHO, 2);
    phase(LUZ_VERDE, LUZ_VERMELHO, 1);
    phase(LUZ_AMARELO, LUZ_VERMELHO, 3);

    // Invalid code for one sample: tracker holds, no sequence error.
    reset_dut(1);
    cycle_ab(1, 3, 2);
    phase(LUZ_VERDE, LUZ_VERMELHO, 1);
    step(1'b0, 3'b110, LUZ_VERMELHO);
    phase(LUZ_AMARELO, LUZ_VERMELHO, 3);
    phase(LUZ_VERMELHO, LUZ_VERMELHO, 2);
    cycle_ab(1, 3, 2);

    // Conflict A=G with B non-red; sticky afterwards.
    reset_dut(1);
    step(1'b0, LUZ_VERDE, LUZ_VERDE);
    step(1'b0, LUZ_AMARELO, LUZ_AMARELO);
    step(1'b0, LUZ_AMARELO, LUZ_VERMELHO);
    step(1'b0, LUZ_AMARELO, LUZ_VERMELHO);
    phase(LUZ_VERMELHO, LUZ_VERMELHO, 2);
    repeat (2) cycle_ab(1, 3, 2);

    // Illegal R->Y on A, then legal wrap: flag stays.
    reset_dut(1);
    phase(LUZ_VERDE, LUZ_VERMELHO, 1);
    phase(LUZ_AMARELO, LUZ_VERMELHO, 3);
    phase(LUZ_VERMELHO, LUZ_VERMELHO, 2);
    phase(LUZ_AMARELO, LUZ_VERMELHO, 3);
    phase(LUZ_VERMELHO, LUZ_VERMELHO, 2);
    repeat (2) cycle_ab(1, 3, 2);

    // Button 4 cycles before A enters red, second pulse ignored, then rst mid-request.
    reset_dut(1);
    cycle_ab(1, 3, 2);
    step(1'b1, LUZ_VERDE, LUZ_VERMELHO);
    step(1'b0, LUZ_AMARELO, LUZ_VERMELHO);
    step(1'b1, LUZ_AMARELO, LUZ_VERMELHO);
    step(1'b0, LUZ_AMARELO, LUZ_VERMELHO);
    step(1'b0, LUZ_VERMELHO, LUZ_VERDE);
    step(1'b0, LUZ_VERMELHO, LUZ_AMARELO);
    cycle_ab(1, 3, 2);
    step(1'b1, LUZ_VERDE, LUZ_VERMELHO);
    step(1'b0, LUZ_AMARELO, LUZ_VERMELHO);
    reset_dut(1);
    cycle_ab(1, 3, 2);

    // Button edge on the same sample A enters red.
    reset_dut(1);
    cycle_ab(1, 3, 2);
    phase(LUZ_VERDE, LUZ_VERMELHO, 1);
    phase(LUZ_AMARELO, LUZ_VERMELHO, 3);
    step(1'b1, LUZ_VERMELHO, LUZ_VERDE);
    step(1'b0, LUZ_VERMELHO, LUZ_AMARELO);
    cycle_ab(1, 3, 2);

    // Randomised phases with occasional faults and resets.
    col = 2;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 24) == 0) reset_dut(1);
      if ($urandom_range(0, 14) == 0) col = $urandom_range(0, 2);
      else col = (col + 1) % 3;
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : dur[col];
      for (int i = 0; i < len; i++) begin
        ra = code(col);
        rb = LUZ_VERMELHO;
        if (col == 2 && len >= 2) rb = (i == len - 1) ? LUZ_AMARELO : LUZ_VERDE;
        if ($urandom_range(0, 59) == 0) ra = 3'($urandom);
        if ($urandom_range(0, 59) == 0) rb = 3'($urandom);
        step($urandom_range(0, 5) == 0, ra, rb);
      end
    end

    @(posedge clk);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
